// File: rtl/serial_work_transmit_pkg.sv
// serial_work_transmit_pkg: constants and state type shared by the work-unit UART link.
// Byte k of a packet is midstate[8k+:8] for k<32, then data2[8(k-32)+:8].
package serial_work_transmit_pkg;
    localparam int PKT_BYTES      = 64;
    localparam int BITS_PER_FRAME = 10;
    localparam int DATA_BITS      = BITS_PER_FRAME - 2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, restarts on demand and ticks on the last clock of a bit.
module uart_baud_tick #(
    parameter int BAUD_DIV = 52
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    logic [15:0] cnt;
    assign tick = cnt == 16'(BAUD_DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (restart || tick) ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/serial_work_transmit.sv
// serial_work_transmit: sends a captured {data2, midstate} work unit as 64 back-to-back 8N1 bytes.
module serial_work_transmit
    import serial_work_transmit_pkg::*;
#(
    parameter int BAUD_DIV  = 52,
    parameter int PKT_BYTES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         send,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         busy,
    output logic         done,
    output logic         TxD
);
    tx_state_t    state;
    logic [511:0] shreg;
    logic [2:0]   bit_idx;
    logic [5:0]   byte_idx;
    logic         tick;
    logic         last_bit;
    logic         last_byte;

    assign last_bit  = bit_idx == 3'(DATA_BITS - 1);
    assign last_byte = byte_idx == 6'(PKT_BYTES - 1);

    // Held in restart while idle so every packet's first bit starts on a fresh count
    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            TxD      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (send) begin
                    shreg <= {data2, midstate};
                    state <= START;
                    busy  <= 1'b1;
                    TxD   <= 1'b0;
                end
                START: if (tick) begin
                    state <= DATA;
                    TxD   <= shreg[0];
                end
                DATA: if (tick) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    state   <= last_bit ? STOP : DATA;
                    TxD     <= last_bit ? 1'b1 : shreg[1];
                end
                STOP: if (tick) begin
                    if (last_byte) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        byte_idx <= '0;
                    end else begin
                        state    <= START;
                        byte_idx <= byte_idx + 6'd1;
                        TxD      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_work_transmit.md
SERIAL_WORK_TRANSMIT -- requirements
Module: serial_work_transmit

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 52: clocks per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter PKT_BYTES, default 64: bytes per work packet; fixed at 64, other values illegal.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port send, input, 1: request to transmit one work packet.
REQ-006 SHALL have port midstate, input, 256: SHA-256 midstate of the work unit.
REQ-007 SHALL have port data2, input, 256: second data block of the work unit.
REQ-008 SHALL have port busy, output, 1: high while a packet is captured or being sent.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at packet completion.
REQ-010 SHALL have port TxD, output, 1: UART 8N1 serial output, idle high.

Function
REQ-011 SHALL sample send, midstate and data2 in the IDLE state only; a send while busy is ignored, not queued.
REQ-012 SHALL capture {data2, midstate} into a 512-bit shift register on the cycle send=1 in IDLE, and SHALL raise busy from the next cycle.
REQ-013 SHALL transmit byte k (k=0..31) as midstate[8k+7:8k] and byte 32+k as data2[8k+7:8k], in byte order 0..63.
REQ-014 SHALL frame each byte as: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV clocks.
REQ-015 SHALL send the bytes back to back with no idle gap; one packet lasts exactly 640*BAUD_DIV clocks of TxD activity.
REQ-016 SHALL drive the first start bit on TxD in the cycle after capture.
REQ-017 SHALL use the state machine IDLE -> START -> DATA -> STOP: STOP goes to START when bytes remain, and goes to IDLE after byte 63.
REQ-018 SHALL count bits in DATA with a 3-bit index and bytes with a 6-bit index; the byte index wraps 63->0 only on the transition to IDLE.
REQ-019 SHALL restart the baud counter at 0 on every bit boundary; the counter SHALL NOT free-run.
REQ-020 SHALL pulse done high for exactly one cycle, on the cycle the FSM enters IDLE, and SHALL drop busy on that same cycle.
REQ-021 SHALL accept a send asserted in the cycle after done, starting a new packet with no extra idle bit time.
REQ-022 SHALL keep TxD registered, with no combinational path from any input to TxD.
REQ-023 SHALL keep input changes to midstate and data2 during busy from affecting the packet in flight.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, TxD=1, busy=0, done=0, and clear all counters and the shift register, regardless of clock.
REQ-025 SHALL abandon a packet in progress when rst is asserted mid-packet; after release, TxD stays high until a new send.
REQ-026 SHALL release reset into IDLE with no spurious done pulse and no start bit.

Structure
REQ-027 SHALL place the shared constants (PKT_BYTES=64, BITS_PER_FRAME=10, byte-ordering definition) in the common hub/miner include header, so the receive side uses identical values.
REQ-028 SHALL factor the bit timing into one sub-module, uart_baud_tick (counter with restart input, tick output at BAUD_DIV-1); the FSM and shift register stay in serial_work_transmit.

Verification
REQ-029 SHALL verify: BAUD_DIV=4, midstate=256'h...0201 (byte0=01, byte1=02), data2=0, one send -> TxD shows 0,10000000,1 then 0,01000000,1 (each bit 4 clocks); done at cycle 1+2560; busy high for exactly 2560 cycles.
REQ-030 SHALL verify: midstate=all A5, data2=all 3C -> a loopback serial_receive model decodes 32 bytes A5 then 32 bytes 3C, and the recovered words equal the inputs.
REQ-031 SHALL verify: send held high continuously for 3 packets -> exactly 3 done pulses, each 2561 cycles apart, with TxD never idle between packets beyond the capture cycle.
REQ-032 SHALL verify: send pulsed at byte 10 of a packet and midstate changed mid-packet -> no extra packet, and the transmitted bytes match the originally captured values.
REQ-033 SHALL verify: rst asserted asynchronously (between clock edges) at byte 20, bit 3 -> TxD=1 immediately, busy=0, no done pulse; a subsequent send produces a complete, correct 64-byte packet.
REQ-034 SHALL verify: BAUD_DIV=2 (minimum) with random work over 100 packets -> all bytes decoded correctly by the reference UART monitor.
